// File: rtl/button_hold_conditioner_pkg.sv
// Shared definitions for the push-button conditioning front end.
//
// Contents:
//   btn_state_t  - per-channel FSM state encoding (3-bit)
//   ms_to_cyc()  - converts a millisecond duration to clock cycles
//   max3()       - largest of three counts, used to size the shared counters
//
// Optional feature macro used by the RTL that imports this package:
//   BTN_HOLD_REPEAT_EN - re-fire hold_pulse periodically while a button stays held
package button_hold_conditioner_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        PRESSED   = 3'd2,
        HELD      = 3'd3,
        DEB_REL   = 3'd4
    } btn_state_t;

    // Divide first so large clock rates do not overflow 32-bit arithmetic.
    function automatic int ms_to_cyc(input int hz, input int ms);
        return hz / 1000 * ms;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/button_hold_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, hold timer.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   pin_pressed   in   raw pin, already normalized to 1 = pressed, asynchronous to clk
//   btn_level     out  debounced pressed level
//   press_pulse   out  1-cycle pulse when a press is accepted
//   release_pulse out  1-cycle pulse when a release is accepted
//   hold_pulse    out  1-cycle pulse when the hold time elapses while pressed
//   hold_active   out  hold has fired and the button is not yet released
//
// Macro BTN_HOLD_REPEAT_EN: when defined, HELD re-fires hold_pulse every
// REP_CYC pressed cycles; when undefined, HELD simply waits for release.
module button_hold_conditioner_channel
    import button_hold_conditioner_pkg::*;
#(
    parameter int DEB_CYC  = 4,
    parameter int HOLD_CYC = 20,
    parameter int REP_CYC  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_pressed,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic hold_active
);

    localparam int CNT_MAX = max3(DEB_CYC, HOLD_CYC, REP_CYC);
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
`ifdef BTN_HOLD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
`endif

    logic sync_q1, sync_q2;
    btn_state_t state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic hold_done_q, hold_done_d;
    logic press_d, release_d, hold_d, level_d, hold_active_d;

    // Synchronizer resets to "released" so a button held through reset
    // is seen as a fresh press once reset lets go.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pin_pressed;
            sync_q2 <= sync_q1;
        end
    end

    // The debounce counter and the hold counter are kept separate so a
    // release glitch that is rejected in DEB_REL resumes the hold timing
    // from where it stopped instead of restarting it.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        hold_done_d = hold_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        hold_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q2) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!sync_q2) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync_q2) begin
                    state_d   = DEB_REL;
                    deb_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = HELD;
                    hold_d      = 1'b1;
                    hold_done_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync_q2) begin
                    state_d   = DEB_REL;
                    deb_cnt_d = '0;
                end
`ifdef BTN_HOLD_REPEAT_EN
                else if (hold_cnt_q == REP_LAST) begin
                    hold_d     = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
            end
            DEB_REL: begin
                if (sync_q2) begin
                    state_d = hold_done_q ? HELD : PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    hold_done_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        level_d       = (state_d == PRESSED) || (state_d == HELD) || (state_d == DEB_REL);
        hold_active_d = hold_done_d && level_d;
    end

    // State, counters and all outputs are registered together so every
    // output changes on the same edge as the state it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            deb_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            hold_done_q   <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
            hold_active   <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_done_q   <= hold_done_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            hold_pulse    <= hold_d;
            hold_active   <= hold_active_d;
        end
    end

endmodule

// File: rtl/button_hold_conditioner.sv
// Push-button front end: NUM_BTN independent conditioned channels.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-low reset
//   btn_in        in   [NUM_BTN] raw button pins, asynchronous to clk
//   btn_level     out  [NUM_BTN] debounced pressed level (1 = pressed)
//   press_pulse   out  [NUM_BTN] 1-cycle pulse on accepted press
//   release_pulse out  [NUM_BTN] 1-cycle pulse on accepted release
//   hold_pulse    out  [NUM_BTN] 1-cycle pulse when HOLD_MS of press time elapses
//   hold_active   out  [NUM_BTN] hold fired and button not yet released
//
// Macro BTN_HOLD_REPEAT_EN: enables periodic re-firing of hold_pulse every
// REPEAT_MS while held; undefined by default.
module button_hold_conditioner
    import button_hold_conditioner_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 5000,
    parameter int REPEAT_MS   = 1000,
    parameter int BTN_ACT_LOW = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] hold_pulse,
    output logic [NUM_BTN-1:0] hold_active
);

    localparam int DEB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int HOLD_CYC = ms_to_cyc(CLK_HZ, HOLD_MS);
    localparam int REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);

    logic [NUM_BTN-1:0] pin_norm;

    // Normalize polarity before synchronizing so every channel sees 1 = pressed.
    assign pin_norm = (BTN_ACT_LOW != 0) ? ~btn_in : btn_in;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_hold_conditioner_channel #(
            .DEB_CYC  (DEB_CYC),
            .HOLD_CYC (HOLD_CYC),
            .REP_CYC  (REP_CYC)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .pin_pressed   (pin_norm[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .hold_pulse    (hold_pulse[i]),
            .hold_active   (hold_active[i])
        );
    end

endmodule

// File: tb/tb_button_hold_conditioner.sv
// Testbench for button_hold_conditioner. A reference model derived from the
// button rules (run lengths of the synchronized sample stream, count of
// pressed time) pushes expected pulse events and levels into queues; a
// monitor on the falling edge pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_button_hold_conditioner;

    localparam int NB   = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] pressed = '0;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level, press_pulse, release_pulse, hold_pulse, hold_active;

    assign btn_in = ~pressed;

    always #5 clk = ~clk;

    button_hold_conditioner #(
        .CLK_HZ      (1000),
        .NUM_BTN     (NB),
        .DEBOUNCE_MS (4),
        .HOLD_MS     (20),
        .REPEAT_MS   (8),
        .BTN_ACT_LOW (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold_pulse    (hold_pulse),
        .hold_active   (hold_active)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int            cyc;
        logic [NB-1:0] pr;
        logic [NB-1:0] rl;
        logic [NB-1:0] hd;
    } ev_t;

    typedef struct {
        int            cyc;
        logic [NB-1:0] lv;
        logic [NB-1:0] ha;
    } lv_t;

    ev_t evq[$];
    lv_t lvq[$];

    // Reference model state: pin samples delayed two edges, debounced level,
    // run of samples disagreeing with the level, counted pressed time.
    logic [NB-1:0] sh1 = '0, sh2 = '0, prev_s = '0, m_level = '0, m_fired = '0;
    logic [NB-1:0] m_s, m_pr, m_rl, m_hd;
    int            run [NB];
    int            hcnt [NB];

    // A level flips once DEB+1 consecutive samples disagree with it. Hold
    // time counts samples where the button is down and was also down on the
    // previous sample; hold fires when that count reaches HOLD (then REP).
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            sh1 = '0; sh2 = '0; prev_s = '0; m_level = '0; m_fired = '0;
            for (int i = 0; i < NB; i++) begin
                run[i]  = 0;
                hcnt[i] = 0;
            end
        end else begin
            m_s = sh2;
            sh2 = sh1;
            sh1 = pressed;
            m_pr = '0; m_rl = '0; m_hd = '0;
            for (int i = 0; i < NB; i++) begin
                if (m_s[i] != m_level[i]) run[i] = run[i] + 1;
                else run[i] = 0;
                if (run[i] == DEB + 1) begin
                    run[i]     = 0;
                    m_level[i] = m_s[i];
                    m_fired[i] = 1'b0;
                    if (m_s[i]) begin
                        m_pr[i] = 1'b1;
                        hcnt[i] = 0;
                    end else begin
                        m_rl[i] = 1'b1;
                    end
                end else if (m_level[i] && m_s[i] && prev_s[i]) begin
                    hcnt[i] = hcnt[i] + 1;
                    if (!m_fired[i] && hcnt[i] == HOLD) begin
                        m_hd[i]    = 1'b1;
                        m_fired[i] = 1'b1;
                        hcnt[i]    = 0;
                    end
`ifdef BTN_HOLD_REPEAT_EN
                    else if (m_fired[i] && hcnt[i] == REP) begin
                        m_hd[i] = 1'b1;
                        hcnt[i] = 0;
                    end
`endif
                end
            end
            prev_s = m_s;
            if ((m_pr | m_rl | m_hd) != '0) evq.push_back('{cyc, m_pr, m_rl, m_hd});
            lvq.push_back('{cyc, m_level, m_fired & m_level});
        end
    end

    // Monitor: pops an expected event whenever the DUT shows a pulse, flags
    // expected events the DUT never produced, and checks levels every cycle.
    ev_t e;
    lv_t l;
    always @(negedge clk) begin
        if (reset) begin
            if ((press_pulse | release_pulse | hold_pulse) != '0) begin
                total++;
                if (evq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL pulse_unexpected cyc=%0d got pr=%b rl=%b hd=%b want none",
                             cyc, press_pulse, release_pulse, hold_pulse);
                end else begin
                    e = evq.pop_front();
                    if (e.cyc != cyc || e.pr !== press_pulse || e.rl !== release_pulse || e.hd !== hold_pulse) begin
                        bad++;
                        $display("[TB] FAIL pulse cyc=%0d got pr=%b rl=%b hd=%b want cyc=%0d pr=%b rl=%b hd=%b",
                                 cyc, press_pulse, release_pulse, hold_pulse, e.cyc, e.pr, e.rl, e.hd);
                    end
                end
            end
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL pulse_missing cyc=%0d got none want pr=%b rl=%b hd=%b at cyc=%0d",
                         cyc, e.pr, e.rl, e.hd, e.cyc);
            end
            if (lvq.size() > 0) begin
                l = lvq.pop_front();
                total++;
                if (l.cyc != cyc || l.lv !== btn_level || l.ha !== hold_active) begin
                    bad++;
                    $display("[TB] FAIL level cyc=%0d got lv=%b ha=%b want cyc=%0d lv=%b ha=%b",
                             cyc, btn_level, hold_active, l.cyc, l.lv, l.ha);
                end
            end
        end
    end

    // Drives a pin pattern (1 = pressed) starting at the current falling edge.
    task automatic apply_stimulus(input logic [NB-1:0] val, input int n);
        pressed = val;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    int seg_left [NB];
    logic [NB-1:0] rnd_val;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_output("reset_level", btn_level, '0);
        check_output("reset_pulses", press_pulse | release_pulse | hold_pulse | hold_active, '0);
        #2 reset = 1'b1;
        @(negedge clk);
        apply_stimulus('0, 5);
        check_output("idle_level", btn_level, '0);

        // Clean press on btn 0: press_pulse exactly 7 edges after the pin edge.
        pressed = 4'b0001;
        repeat (6) @(negedge clk);
        check_output("press_early", press_pulse, '0);
        @(negedge clk);
        check_output("press_latency", press_pulse, 4'b0001);
        check_output("press_level", btn_level, 4'b0001);
        // Hold 30 cycles past the press, then release.
        repeat (30) @(negedge clk);
        check_output("hold_active_on", hold_active, 4'b0001);
        apply_stimulus('0, 12);
        check_output("hold_active_off", hold_active, '0);

        // Bounce on btn 2, then steady for 50 cycles to cover hold (and repeat).
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(4'b0100, 2);
            apply_stimulus(4'b0000, 3);
        end
        apply_stimulus(4'b0100, 7 + 45);
        apply_stimulus('0, 12);

        // Release glitch of 2 cycles at 10 counts of pressed time on btn 3.
        apply_stimulus(4'b1000, 7 + 10);
        apply_stimulus(4'b0000, 2);
        apply_stimulus(4'b1000, 25);
        apply_stimulus('0, 12);

        // All channels at once.
        apply_stimulus(4'b1111, 12);
        apply_stimulus('0, 12);

        // Reset in HELD with btn 1 still pressed.
        apply_stimulus(4'b0010, 7 + 25);
        #2 reset = 1'b0;
        #1;
        check_output("async_reset_level", btn_level, '0);
        check_output("async_reset_hold", hold_active, '0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        repeat (6) @(negedge clk);
        check_output("post_reset_early", press_pulse, '0);
        @(negedge clk);
        check_output("post_reset_press", press_pulse, 4'b0010);
        apply_stimulus(4'b0010, 10);
        apply_stimulus('0, 12);

        // Randomized segments per channel.
        for (int i = 0; i < NB; i++) seg_left[i] = 0;
        rnd_val = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (seg_left[i] == 0) begin
                    rnd_val[i]  = ~rnd_val[i];
                    seg_left[i] = (($urandom % 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
                end
                seg_left[i]--;
            end
            apply_stimulus(rnd_val, 1);
        end
        apply_stimulus('0, 20);

        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got=%0d pending want=0", evq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
